fir_sched: RTL
==============

# fir_sched

Two-channel scheduler that shares one pre-add/multiply/accumulate unit between the left and right PCM streams of the karaoke audio path, implementing the same 32-tap symmetric Q15 compensation filter on each channel. It arbitrates round-robin between the two input streams and sequences the per-channel 32-entry circular delay lines through the 16 unique coefficients. It emits one tagged, saturated Q15 result per accepted sample over a valid/ready output handshake. It sits between the I2S receive framing and the mixer, replacing two fully parallel filter instances.

## Interface
- COEF_SHIFT, 15: right-shift applied to the accumulator (Q30 to Q15).
- SATURATE, 1: 1 clamps the result to the 16-bit range; 0 truncates to the low 16 bits.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both delay lines, both pointers and any pending or in-flight result.
- ch0_data / ch1_data  in  16  signed Q15 sample per channel.
- ch0_valid / ch1_valid  in  1  sample offered.
- ch0_ready / ch1_ready  out  1  sample accepted when valid & ready.
- y_out  out  16  signed Q15 filtered sample.
- y_ch  out  1  channel tag for y_out.
- y_valid  out  1  result available; held with y_out/y_ch stable until y_ready.
- y_ready  in  1  downstream accepts.
- busy  out  1  high in every state except IDLE.

## Operation
- Coefficients c[0..15] = 0, -3, 11, -27, 39, -11, -98, 277, -392, 203, 471, -1475, 2137, -1328, -2638, 19218. Tap k (0..31) uses c[k] for k<16 and c[31-k] otherwise. The coefficients sum to 32768, so DC gain is exactly 1.
- Per-channel storage: 32x16 delay line, 5-bit write pointer wp. Reset/flush: all entries 0, wp=0.
- Accepting a sample writes it at address wp+1 (mod 32), and wp takes that value. Tap k then reads address wp-k (mod 32); k=0 is the newest sample. Wrap-around is natural modulo 32.
- FSM:
  - IDLE: ready is asserted to the granted channel only.
    - Grant rules: if only one channel's valid is high, grant that channel. If both are high, grant the channel not granted last. The last-grant bit resets to 1, so ch0 wins the first tie.
    - On handshake, latch the channel and go to MAC.
  - MAC (16 cycles, k=0..15): pair = tap[k] + tap[31-k] (17-bit signed), prod = pair*c[k] (33-bit), acc += prod (38-bit signed). acc is cleared on entry.
  - SCALE (1 cycle): r = acc >>> COEF_SHIFT (arithmetic). If SATURATE, clamp to [-32768, 32767]. Register the result into y_out, set y_ch, assert y_valid. Go to OUT.
  - OUT: hold until y_valid & y_ready, then deassert y_valid and go to IDLE.
- Both ready signals are 0 outside IDLE. There is no input buffering: a source must hold valid until it is accepted.
- Outputs are produced from the first sample; no warm-up suppression. Unwritten taps read as 0.
- Flush:
  - Highest priority in any state.
  - Next cycle: state = IDLE, y_valid = 0, buffers and pointers cleared, last-grant bit unchanged.
  - A handshake in the same cycle as flush is discarded.

## Timing
- Reset values: y_out=0, y_ch=0, y_valid=0, ch0_ready=0, ch1_ready=0, busy=0; FSM in IDLE.
- Ready may assert combinationally from IDLE state and valid (no valid-to-ready loop through the source).
- Latency: handshake on edge T, MAC on edges T+1..T+16, SCALE on T+17. y_valid is high after edge T+17.
- If y_ready is already high, y_valid drops after edge T+18 and the next handshake can occur on edge T+19. Minimum spacing is 19 cycles per sample; both channels alternating need 38 cycles per stereo pair.
- A y_ready stall extends OUT indefinitely; both ready signals stay low throughout.
- Simultaneous arrival of a new valid and the output handshake: the new sample is not accepted until the cycle after returning to IDLE.

## Test plan
- Impulse on ch0: one sample -32768, then 31 zeros, y_ready tied high.
  - Outputs in order: 0, 3, -11, 27, -39, 11, 98, -277, 392, -203, -471, 1475, -2137, 1328, 2638, -19218.
  - Then the same 16 values mirrored, each tagged y_ch=0.
- DC step: 40 samples of 1000 on ch1. Output ramps, then equals exactly 1000 from the 32nd output on; ch0 delay line unaffected.
- Arbitration: both valid continuously, distinct data.
  - Grants alternate ch0, ch1, ch0, ...; y_ch alternates accordingly.
  - Each handshake is at least 19 cycles after the previous one.
- Backpressure: y_ready low for 50 cycles after y_valid.
  - y_out and y_ch stay stable; both ready signals stay 0.
  - The next accept occurs 1 cycle after y_ready rises.
- Saturation: fill ch0 so that tap k and tap 31-k equal +32767 where c[k]>0 and -32768 where c[k]<0.
  - SATURATE=1 gives 32767; SATURATE=0 gives the truncated low 16 bits.
- Flush/reset mid-MAC: assert flush at cycle T+8.
  - y_valid never rises for that sample; next output equals c[0]-scaled impulse response from a cleared line.
  - Repeat with reset_n low mid-OUT: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fir_sched.sv
// Two-channel round-robin scheduler around one shared pre-add/multiply/accumulate
// unit, running the same 32-tap symmetric Q15 filter on each PCM channel.
module fir_sched #(
  parameter int unsigned COEF_SHIFT = 15,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic signed [15:0] ch0_data,
  input  logic               ch0_valid,
  output logic               ch0_ready,
  input  logic signed [15:0] ch1_data,
  input  logic               ch1_valid,
  output logic               ch1_ready,
  output logic signed [15:0] y_out,
  output logic               y_ch,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               busy
);

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 5;
  localparam int unsigned TAPS = 32;
  localparam int unsigned HALF = 16;
  localparam int unsigned KW   = 4;
  localparam int unsigned PW   = DW + 1;
  localparam int unsigned MW   = PW + DW;
  localparam int unsigned ACCW = 38;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

  state_t                 state;
  logic signed [DW-1:0]   dl0 [TAPS];
  logic signed [DW-1:0]   dl1 [TAPS];
  logic [AW-1:0]          wp0;
  logic [AW-1:0]          wp1;
  logic                   last_grant;
  logic                   cur_ch;
  logic [KW-1:0]          k;
  logic signed [ACCW-1:0] acc;

  logic                   idle_c;
  logic                   grant_c;
  logic [AW-1:0]          wp_sel_c;
  logic [AW-1:0]          rd_new_c;
  logic [AW-1:0]          rd_old_c;
  logic signed [DW-1:0]   tap_new_c;
  logic signed [DW-1:0]   tap_old_c;
  logic signed [DW-1:0]   coef_c;
  logic signed [PW-1:0]   pair_c;
  logic signed [MW-1:0]   prod_c;
  logic signed [ACCW-1:0] scaled_c;
  logic signed [DW-1:0]   result_c;

  // Unique half of the symmetric impulse response; tap k and tap 31-k share c[k].
  function automatic logic signed [15:0] coef(input logic [3:0] i);
    case (i)
      4'd0:    coef = 16'sd0;
      4'd1:    coef = -16'sd3;
      4'd2:    coef = 16'sd11;
      4'd3:    coef = -16'sd27;
      4'd4:    coef = 16'sd39;
      4'd5:    coef = -16'sd11;
      4'd6:    coef = -16'sd98;
      4'd7:    coef = 16'sd277;
      4'd8:    coef = -16'sd392;
      4'd9:    coef = 16'sd203;
      4'd10:   coef = 16'sd471;
      4'd11:   coef = -16'sd1475;
      4'd12:   coef = 16'sd2137;
      4'd13:   coef = -16'sd1328;
      4'd14:   coef = -16'sd2638;
      4'd15:   coef = 16'sd19218;
      default: coef = '0;
    endcase
  endfunction

  // Grant, tap fetch for the symmetric pair, pre-add/multiply and output scaling.
  always_comb begin
    idle_c    = (state == IDLE);
    grant_c   = (ch0_valid && ch1_valid) ? ~last_grant : ch1_valid;
    wp_sel_c  = cur_ch ? wp1 : wp0;
    rd_new_c  = wp_sel_c - AW'(k);
    rd_old_c  = wp_sel_c + AW'(k) + AW'(1);
    tap_new_c = cur_ch ? dl1[rd_new_c] : dl0[rd_new_c];
    tap_old_c = cur_ch ? dl1[rd_old_c] : dl0[rd_old_c];
    pair_c    = PW'(tap_new_c) + PW'(tap_old_c);
    coef_c    = coef(k);
    prod_c    = MW'(pair_c) * MW'(coef_c);
    scaled_c  = acc >>> COEF_SHIFT;
    result_c  = scaled_c[DW-1:0];
    if (SATURATE) begin
      if (scaled_c > SAT_MAX) begin
        result_c = 16'sh7fff;
      end else if (scaled_c < SAT_MIN) begin
        result_c = 16'sh8000;
      end
    end
  end

  assign ch0_ready = idle_c & ch0_valid & ~grant_c;
  assign ch1_ready = idle_c & ch1_valid & grant_c;

  // Scheduler FSM, delay lines and registered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wp0        <= '0;
      wp1        <= '0;
      last_grant <= 1'b1;
      cur_ch     <= 1'b0;
      k          <= '0;
      acc        <= '0;
      y_out      <= '0;
      y_ch       <= 1'b0;
      y_valid    <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        dl0[i] <= '0;
        dl1[i] <= '0;
      end
    end else if (flush) begin
      state   <= IDLE;
      wp0     <= '0;
      wp1     <= '0;
      k       <= '0;
      acc     <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        dl0[i] <= '0;
        dl1[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if ((ch0_valid && ch0_ready) || (ch1_valid && ch1_ready)) begin
            cur_ch     <= grant_c;
            last_grant <= grant_c;
            k          <= '0;
            acc        <= '0;
            state      <= MAC;
            busy       <= 1'b1;
            if (grant_c) begin
              dl1[wp1 + AW'(1)] <= ch1_data;
              wp1               <= wp1 + AW'(1);
            end else begin
              dl0[wp0 + AW'(1)] <= ch0_data;
              wp0               <= wp0 + AW'(1);
            end
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod_c);
          k   <= k + KW'(1);
          if (k == KW'(HALF - 1)) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          y_out   <= result_c;
          y_ch    <= cur_ch;
          y_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
